// File: rtl/ah_credit_tx_pkg.sv
// Shared definitions for the credit-flow link: widths, log2 helper and the
// pointer-compare functions used by both transmitter and receiver buffers.
package ah_credit_tx_pkg;

   localparam int DATA_W_DEF = 10;

   function automatic int clog2(input int value);
      int res;
      int x;
      res = 0;
      x   = value - 1;
      while (x > 0) begin
         res = res + 1;
         x   = x >> 1;
      end
      return res;
   endfunction

   // Width needed to hold every value 0..credits inclusive.
   function automatic int cnt_w(input int credits);
      return clog2(credits + 1);
   endfunction

   function automatic logic ptr_empty(input int wr, input int rd);
      return wr == rd;
   endfunction

   // Pointers carry one extra wrap bit above the aw index bits.
   function automatic logic ptr_full(input int wr, input int rd, input int aw);
      return (wr ^ rd) == (1 << aw);
   endfunction

endpackage

// File: rtl/ah_credit_tx_buf.sv
// Circular staging buffer with wrap-bit pointers; head entry is always
// visible on head_data so the pop can register it directly.
module ah_credit_tx_buf
   import ah_credit_tx_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = 4,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty
);

   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [DATA_W-1:0] mem [DEPTH];

   assign full      = ptr_full(int'(wr_ptr), int'(rd_ptr), AW);
   assign empty     = ptr_empty(int'(wr_ptr), int'(rd_ptr));
   assign head_data = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/ah_credit_tx.sv
// Credit-based transmitter: stages producer words and launches one per cycle
// toward the receiver while credit is held.
module ah_credit_tx
   import ah_credit_tx_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int CREDITS   = 16,
   parameter int BUF_DEPTH = 4,
   localparam int CW       = cnt_w(CREDITS)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              credit_in,
   output logic [CW-1:0]     credit_cnt,
   output logic              idle,
   output logic              credit_err
);

   localparam logic [CW-1:0] CNT_FULL = CW'(CREDITS);

   logic              buf_full;
   logic              buf_empty;
   logic [DATA_W-1:0] head_data;
   logic              push;
   logic              send;

   // Producer handshake: a word transfers on a rising edge where in_valid and
   // in_ready are both high; in_ready comes only from registered pointers.
   assign in_ready = !buf_full;
   assign push     = in_valid && in_ready;
   assign send     = !buf_empty && (credit_cnt != '0);
   assign idle     = buf_empty && !tx_valid && (credit_cnt == CNT_FULL);

   ah_credit_tx_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data (in_data),
      .pop       (send),
      .head_data (head_data),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         tx_valid <= send;
         if (send) tx_data <= head_data;
      end
   end

   // A returned credit with a launch in the same cycle cancels out; a credit
   // arriving at the full count is a protocol error and is dropped.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit_cnt <= CNT_FULL;
         credit_err <= 1'b0;
      end else begin
         if (send && !credit_in) begin
            credit_cnt <= credit_cnt - CW'(1);
         end else if (!send && credit_in) begin
            if (credit_cnt == CNT_FULL) credit_err <= 1'b1;
            else                        credit_cnt <= credit_cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_ah_credit_tx.sv
// Bench for ah_credit_tx: cycle-level reference model (queue + counter) and a
// scoreboard of accepted words checked against every launched word.
module tb_ah_credit_tx;

   localparam int W       = 10;
   localparam int CREDITS = 16;
   localparam int DEPTH   = 4;

   logic         clk;
   logic         rstn;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic         credit_in;
   logic [4:0]   credit_cnt;
   logic         idle;
   logic         credit_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [W-1:0] buf_q[$];
   logic [W-1:0] exp_q[$];
   int           m_cnt;
   bit           m_err;
   bit           m_tx_valid;
   logic [W-1:0] m_tx_data;
   bit           last_push;
   int           tx_count;

   ah_credit_tx #(
      .DATA_W    (W),
      .CREDITS   (CREDITS),
      .BUF_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .credit_in  (credit_in),
      .credit_cnt (credit_cnt),
      .idle       (idle),
      .credit_err (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      buf_q.delete();
      exp_q.delete();
      m_cnt      = CREDITS;
      m_err      = 1'b0;
      m_tx_valid = 1'b0;
      m_tx_data  = '0;
   endtask

   task automatic compare_all();
      chk("in_ready",   32'(in_ready),   32'(buf_q.size() < DEPTH));
      chk("tx_valid",   32'(tx_valid),   32'(m_tx_valid));
      chk("tx_data",    32'(tx_data),    32'(m_tx_data));
      chk("credit_cnt", 32'(credit_cnt), 32'(m_cnt));
      chk("idle",       32'(idle),       32'(buf_q.size() == 0 && !m_tx_valid && m_cnt == CREDITS));
      chk("credit_err", 32'(credit_err), 32'(m_err));
   endtask

   // One clock cycle: drive inputs, advance the model at the edge, compare at negedge.
   task automatic cycle(input bit v, input logic [W-1:0] d, input bit c);
      bit m_send;
      bit m_push;
      in_valid  = v;
      in_data   = d;
      credit_in = c;
      @(posedge clk);
      m_send    = (buf_q.size() != 0) && (m_cnt != 0);
      m_push    = v && (buf_q.size() < DEPTH);
      last_push = m_push;
      if (m_push) exp_q.push_back(d);
      if (m_send) begin
         m_tx_data  = buf_q.pop_front();
         m_tx_valid = 1'b1;
      end else begin
         m_tx_valid = 1'b0;
      end
      if (m_push) buf_q.push_back(d);
      if (m_send && !c) m_cnt--;
      else if (!m_send && c) begin
         if (m_cnt == CREDITS) m_err = 1'b1;
         else                  m_cnt++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      credit_in = 1'b0;
      compare_all();
      if (tx_valid === 1'b1) begin
         tx_count++;
         chk("sb_has_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) chk("sb_order", 32'(tx_data), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b0);
   endtask

   // Push n words with no credit return, bounded by a cycle budget.
   task automatic push_words(input int n, input logic [W-1:0] base);
      int k;
      int budget;
      k = 0;
      budget = 0;
      while (k < n && budget < 200) begin
         cycle(1'b1, base + W'(k), 1'b0);
         if (last_push) k++;
         budget++;
      end
      chk("push_words_done", 32'(k), 32'(n));
   endtask

   // Return credits until the link is back at rest.
   task automatic drain();
      int budget;
      budget = 0;
      while ((buf_q.size() != 0 || m_cnt < CREDITS || m_tx_valid) && budget < 200) begin
         cycle(1'b0, '0, m_cnt < CREDITS);
         budget++;
      end
      chk("drain_idle", 32'(idle), 32'd1);
   endtask

   initial begin
      int next_val;
      int rx;
      int n;
      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      credit_in = 1'b0;
      tx_count  = 0;
      reset_model();

      // 1: reset then idle
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      compare_all();
      chk("rst_credit_cnt", 32'(credit_cnt), 32'd16);
      idle_cycles(2);
      chk("rst_idle", 32'(idle), 32'd1);

      // 2: single word, two-cycle latency
      cycle(1'b1, 10'h155, 1'b0);
      chk("single_c1_valid", 32'(tx_valid), 32'd0);
      cycle(1'b0, '0, 1'b0);
      chk("single_c2_valid", 32'(tx_valid), 32'd1);
      chk("single_c2_data",  32'(tx_data),  32'h155);
      cycle(1'b0, '0, 1'b0);
      chk("single_c3_valid", 32'(tx_valid), 32'd0);
      chk("single_c3_cnt",   32'(credit_cnt), 32'd15);
      drain();

      // 3: credit exhaustion, then three credits release three words
      tx_count = 0;
      push_words(20, 10'h100);
      idle_cycles(3);
      chk("exhaust_tx_count", 32'(tx_count), 32'd16);
      chk("exhaust_cnt",      32'(credit_cnt), 32'd0);
      chk("exhaust_ready",    32'(in_ready), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
      idle_cycles(3);
      chk("release_tx_count", 32'(tx_count), 32'd19);
      chk("release_cnt",      32'(credit_cnt), 32'd0);
      drain();

      // 4a: send and credit return in the same cycle at count 5
      push_words(11, 10'h040);
      idle_cycles(3);
      chk("cnt5_before", 32'(credit_cnt), 32'd5);
      cycle(1'b1, 10'h2aa, 1'b0);
      cycle(1'b0, '0, 1'b1);
      chk("cnt5_send_valid", 32'(tx_valid), 32'd1);
      chk("cnt5_after",      32'(credit_cnt), 32'd5);
      drain();

      // 4b: credit at count 0 enables a send only in the next cycle
      push_words(17, 10'h080);
      idle_cycles(3);
      chk("zero_cnt", 32'(credit_cnt), 32'd0);
      cycle(1'b0, '0, 1'b1);
      chk("zero_credit_same_valid", 32'(tx_valid), 32'd0);
      chk("zero_credit_same_cnt",   32'(credit_cnt), 32'd1);
      cycle(1'b0, '0, 1'b0);
      chk("zero_credit_next_valid", 32'(tx_valid), 32'd1);
      drain();

      // 5: random traffic, sequential values, wrap-around
      next_val = 0;
      rx = 0;
      n = 0;
      tx_count = 0;
      while ((next_val < 50 || tx_count < 50) && n < 3000) begin
         bit v;
         bit c;
         v = (next_val < 50) && ($urandom_range(0, 1) == 1);
         c = (m_cnt < CREDITS) && ($urandom_range(0, 2) == 0);
         cycle(v, W'(next_val), c);
         if (last_push) next_val++;
         n++;
      end
      rx = tx_count;
      chk("rand_rx_count", 32'(rx), 32'd50);
      chk("rand_outstanding", 32'(credit_cnt), 32'(CREDITS - 50 + (m_cnt - (CREDITS - 50))));
      drain();

      // 6a: credit overflow is sticky
      cycle(1'b0, '0, 1'b1);
      chk("ovf_cnt", 32'(credit_cnt), 32'd16);
      chk("ovf_err", 32'(credit_err), 32'd1);
      idle_cycles(2);
      chk("ovf_err_sticky", 32'(credit_err), 32'd1);

      // 6b: reset with three words buffered and tx_valid high
      push_words(20, 10'h200);
      idle_cycles(3);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b0);
      chk("pre_rst_valid", 32'(tx_valid), 32'd1);
      chk("pre_rst_buffered", 32'(buf_q.size()), 32'd3);
      rstn = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(tx_valid),   32'd0);
      chk("rst_mid_data",  32'(tx_data),    32'd0);
      chk("rst_mid_ready", 32'(in_ready),   32'd1);
      chk("rst_mid_cnt",   32'(credit_cnt), 32'd16);
      chk("rst_mid_idle",  32'(idle),       32'd1);
      chk("rst_mid_err",   32'(credit_err), 32'd0);
      reset_model();
      @(negedge clk);
      rstn = 1'b1;
      idle_cycles(2);
      cycle(1'b1, 10'h3c3, 1'b0);
      idle_cycles(3);
      chk("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
